line_pixel_packer: RTL

- Downstream stage of the line-scanner capture unit, clocked by pixel_clock.
- Collects 8-bit pixels strobed by pixel_captured while lval is high and packs 4 pixels per 32-bit word.
- Marks the first word of each line (tuser) and the last (tlast), and buffers words in an internal FIFO.
- Presents words on a valid/ready stream to the DMA/bus side.

---
 rtl/line_pixel_packer_if.sv | 22 ++
 rtl/line_pixel_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/line_pixel_packer_if.sv
// Pixel capture inputs and packed-word stream of the line pixel packer.
// master = packer side, slave = capture unit / DMA side.
interface line_pixel_packer_if;
    logic        lval;
    logic [7:0]  pixel_data;
    logic        pixel_captured;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;

    modport master (
        input  lval, pixel_data, pixel_captured, m_tready,
        output m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport slave (
        output lval, pixel_data, pixel_captured, m_tready,
        input  m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/line_pixel_packer.sv
// Generic synchronous FIFO: binary pointers with an extra wrap bit.
// Latency: written entry visible at the head one cycle after its write edge.
// Backpressure: wr_rdy low when full unless a read happens on the same edge.
module lpp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic             pixel_clock,
    input  logic             rst_cds,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = !empty && rd_rdy;
    assign wr_rdy = !full || do_rd;
    assign do_wr  = wr_vld && wr_rdy;
    assign rd_vld = !empty;
    // Head is forced to zero when empty so the stream outputs read 0 out of reset.
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge pixel_clock or negedge rst_cds) begin
        if (!rst_cds) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// Packs 4 line-scanner pixels per 32-bit word, tags first/last word of a line.
// Latency: a word reaches the FIFO at the next completion or at line end, +1 cycle to m_tvalid.
// Backpressure: FIFO absorbs stalls; words arriving on a full FIFO are dropped, overflow sticks.
module line_pixel_packer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int LINE_CNT_WIDTH = 16
) (
    input  logic                      pixel_clock,
    input  logic                      rst_cds,
    input  logic                      enable,
    line_pixel_packer_if.master       px,
    output logic                      overflow,
    output logic [LINE_CNT_WIDTH-1:0] line_count
);
    typedef struct packed {
        logic        user;
        logic        last;
        logic [31:0] dat;
    } word_t;

    localparam logic [LINE_CNT_WIDTH-1:0] CNT_ONE = {{(LINE_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic        lval_d;
    logic [1:0]  idx;
    logic [7:0]  lane0;
    logic [7:0]  lane1;
    logic [7:0]  lane2;
    logic        first_flag;
    logic        stage_vld;
    word_t       stage;
    logic        flush_pend;
    word_t       flush_word;

    logic        capture;
    logic        line_end;
    logic        word_done;
    logic [31:0] full_dat;
    logic [31:0] partial_dat;
    logic        wr_vld;
    word_t       wr_word;
    logic        wr_rdy;
    logic        rd_vld;
    word_t       head;

    assign capture   = enable && px.lval && px.pixel_captured;
    assign line_end  = lval_d && !px.lval;
    assign word_done = capture && (idx == 2'd3);
    assign full_dat  = {px.pixel_data, lane2, lane1, lane0};

    always_comb begin
        partial_dat = '0;
        case (idx)
            2'd1:    partial_dat = {24'h0, lane0};
            2'd2:    partial_dat = {16'h0, lane1, lane0};
            2'd3:    partial_dat = {8'h0, lane2, lane1, lane0};
            default: partial_dat = '0;
        endcase
    end

    // One FIFO write per edge. The deferred partial flush cannot coincide with
    // a line end or a word completion: both need lval history the flush edge lacks.
    always_comb begin
        wr_vld  = 1'b0;
        wr_word = '0;
        if (flush_pend) begin
            wr_vld  = 1'b1;
            wr_word = flush_word;
        end else if (line_end) begin
            if (stage_vld) begin
                wr_vld       = 1'b1;
                wr_word      = stage;
                wr_word.last = (idx == 2'd0);
            end
        end else if (word_done && stage_vld) begin
            wr_vld  = 1'b1;
            wr_word = stage;
        end
    end

    always_ff @(posedge pixel_clock or negedge rst_cds) begin
        if (!rst_cds) begin
            lval_d     <= 1'b0;
            idx        <= 2'd0;
            lane0      <= 8'h0;
            lane1      <= 8'h0;
            lane2      <= 8'h0;
            first_flag <= 1'b1;
            stage_vld  <= 1'b0;
            stage      <= '0;
            flush_pend <= 1'b0;
            flush_word <= '0;
            overflow   <= 1'b0;
            line_count <= '0;
        end else begin
            lval_d     <= px.lval;
            flush_pend <= 1'b0;

            if (wr_vld && !wr_rdy) overflow <= 1'b1;

            if (line_end) begin
                idx        <= 2'd0;
                first_flag <= 1'b1;
                stage_vld  <= 1'b0;
                line_count <= line_count + CNT_ONE;
                if (idx != 2'd0) begin
                    flush_pend <= 1'b1;
                    flush_word <= '{user: first_flag, last: 1'b1, dat: partial_dat};
                end
            end else if (capture) begin
                idx <= idx + 2'd1;
                case (idx)
                    2'd0:    lane0 <= px.pixel_data;
                    2'd1:    lane1 <= px.pixel_data;
                    2'd2:    lane2 <= px.pixel_data;
                    default: ;
                endcase
                if (word_done) begin
                    stage_vld  <= 1'b1;
                    stage      <= '{user: first_flag, last: 1'b0, dat: full_dat};
                    first_flag <= 1'b0;
                end
            end
        end
    end

    lpp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .pixel_clock (pixel_clock),
        .rst_cds     (rst_cds),
        .wr_vld      (wr_vld),
        .wr_dat      (wr_word),
        .wr_rdy      (wr_rdy),
        .rd_vld      (rd_vld),
        .rd_dat      (head),
        .rd_rdy      (px.m_tready)
    );

    assign px.m_tvalid = rd_vld;
    assign px.m_tdata  = head.dat;
    assign px.m_tlast  = head.last;
    assign px.m_tuser  = head.user;
endmodule
